instr_fetch: RTL

Instruction fetch stage directly upstream of the instruction decoder. It owns the program counter and issues word reads to synchronous instruction memory. Returned 16-bit instruction words are buffered in a 2-entry queue and presented to the decoder with a valid/ready handshake. Branch/jump redirects from the execute stage flush the queue and squash any in-flight read.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue.sv | 52 +++++
 rtl/instr_fetch.sv | 105 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
// Queue entries pair a fetched word with its word address.
package fetch_pkg;

  localparam int INSTR_W      = 16;
  localparam int FETCH_ADDR_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0]      instr;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of fetched instructions.
// Flush beats push; push and pop may coincide at any fill level.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem_q [2];
  logic         rd_q;
  logic         wr_q;
  logic [1:0]   cnt_q;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop && (cnt_q != 2'd0);
  assign do_push = push && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, memory read issue, 2-deep instruction queue.
// Redirects flush the queue and discard the read returning that cycle.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fetch_en,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] infl_pc_q;
  logic              infl_q;
  logic [1:0]        count;
  fetch_entry_t      head;
  fetch_entry_t      push_ent;
  logic              pop;
  logic              push;
  logic              room;
  logic              issue;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fetch_en)  state_d = RUN;
      RUN:     if (!fetch_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid & instr_ready;
  assign room        = (count + {1'b0, infl_q}) < 2'd2;

  always_comb begin
    issue = 1'b0;
    unique case (state_q)
      RUN:     issue = fetch_en & ~redirect & (room | pop);
      default: issue = 1'b0;
    endcase
    mem_rd_en = issue;
    mem_addr  = pc_q;
  end

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      redirect: pc_d = redirect_pc;
      issue:    pc_d = pc_q + ADDR_W'(1);
      default:  ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      pc_q   <= pc_d;
      infl_q <= issue;
      if (issue) infl_pc_q <= pc_q;
    end
  end

  // Read latency is one cycle, so a read outstanding during a redirect
  // returns in that same cycle and is squashed by gating its push.
  assign push     = infl_q & ~redirect;
  assign push_ent = '{instr: mem_rdata, pc: FETCH_ADDR_W'(infl_pc_q)};

  fetch_queue u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_ent),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

  assign instr    = instr_valid ? head.instr : '0;
  assign instr_pc = instr_valid ? ADDR_W'(head.pc) : RESET_PC;

endmodule
